// File: rtl/grant_burst_mux_pkg.sv
// grant_burst_mux_pkg: shared FSM state type and default sizing for the grant burst mux and its arbiter
package grant_burst_mux_pkg;
  localparam int DEF_N  = 4;
  localparam int DEF_DW = 8;
  localparam int DEF_LW = 3;
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;
endpackage

// File: rtl/grant_burst_mux_onehot_enc.sv
// onehot_enc: one-hot to index encoder, flags whether the input is exactly one-hot
module onehot_enc
  import grant_burst_mux_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          valid_onehot
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) idx = vec[i] ? (idx | IW'(i)) : idx;
  end
  assign valid_onehot = (vec != '0) && ((vec & (vec - 1'b1)) == '0);
endmodule

// File: rtl/grant_burst_mux.sv
// grant_burst_mux: streams a granted requester's burst (len+1 beats) to a shared resource with backpressure
module grant_burst_mux
  import grant_burst_mux_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW,
  parameter int LW = DEF_LW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         grant,
  input  logic [N*DW-1:0]      req_data,
  input  logic [N*LW-1:0]      req_len,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [$clog2(N)-1:0] out_id,
  output logic                 out_last,
  output logic [N-1:0]         done,
  output logic                 busy,
  output logic                 err_grant
);
  localparam int IW = $clog2(N);
  state_e        state_q, state_d;
  logic [IW-1:0] id_q, id_d, enc_idx, sel;
  logic [LW-1:0] len_q, len_d, beat_cnt_q, beat_cnt_d, lane_len;
  logic [DW-1:0] data_q, data_d, lane_data;
  logic          err_q, err_d, enc_valid;
  onehot_enc #(.N(N), .IW(IW)) u_enc (
    .vec          (grant),
    .idx          (enc_idx),
    .valid_onehot (enc_valid)
  );
  // In IDLE the lane comes from the live grant; afterwards only the latched id matters
  assign sel       = (state_q == IDLE) ? enc_idx : id_q;
  assign lane_data = req_data[sel*DW +: DW];
  assign lane_len  = req_len[sel*LW +: LW];
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    data_d     = data_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d    = XFER;
          id_d       = enc_idx;
          len_d      = lane_len;
          data_d     = lane_data;
          beat_cnt_d = '0;
        end else if (grant != '0) begin
          err_d = 1'b1;
        end
      end
      XFER: begin
        if (out_ready) begin
          state_d    = (beat_cnt_q == len_q) ? DONE : XFER;
          beat_cnt_d = (beat_cnt_q == len_q) ? beat_cnt_q : beat_cnt_q + 1'b1;
          data_d     = (beat_cnt_q == len_q) ? data_q : lane_data;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      id_q       <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end
  assign out_valid = (state_q == XFER);
  assign out_last  = out_valid && (beat_cnt_q == len_q);
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign done      = (state_q == DONE) ? (N'(1) << id_q) : '0;
  assign busy      = (state_q != IDLE);
  assign err_grant = err_q;
endmodule
